// File: rtl/obi_arb_pkg.sv
// rtl/obi_arb_pkg.sv - shared state encoding and default widths for the OBI round-robin arbiter
package obi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        RESP = 2'b10
    } arb_state_e;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;

endpackage

// File: rtl/obi_rr_arbiter_if.sv
// rtl/obi_rr_arbiter_if.sv - OBI manager-port bundle (A-channel and R-channel)
interface obi_rr_arbiter_if
    import obi_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                    req;
    logic                    gnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    err;

    modport master (
        output req, addr, we, be, wdata, rready,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata, rready,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/obi_rr_pick.sv
// rtl/obi_rr_pick.sv - combinational wrapped priority search starting at ptr_i
module obi_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);
    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan from the farthest offset down so the nearest set bit at or above ptr wins.
    always_comb begin
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand     = (int'(ptr_i) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (req_i[cand_idx]) begin
                idx_o   = cand_idx;
                valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/obi_rr_arbiter.sv
// rtl/obi_rr_arbiter.sv - round-robin arbiter sharing one OBI manager port, one transfer in flight
module obi_rr_arbiter
    import obi_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                            clk_i,
    input  logic                            reset_ni,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ-1:0]              we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] be_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]              gnt_o,
    output logic [NUM_REQ-1:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]           rdata_o,
    output logic                            err_o,
    obi_rr_arbiter_if.master                obi
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BE_W  = DATA_WIDTH / 8;

    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      sel_q, sel_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BE_W-1:0]       be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [BE_W-1:0]       be_arr    [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign be_arr[g]    = be_i[g*BE_W +: BE_W];
        assign wdata_arr[g] = wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    obi_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        sel_d      = sel_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        gnt_o      = '0;
        rvalid_o   = '0;
        rdata_o    = '0;
        err_o      = 1'b0;
        obi.req    = 1'b0;
        obi.addr   = '0;
        obi.we     = 1'b0;
        obi.be     = '0;
        obi.wdata  = '0;
        obi.rready = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    sel_d   = pick_idx;
                    we_d    = we_i[pick_idx];
                    addr_d  = addr_arr[pick_idx];
                    be_d    = be_arr[pick_idx];
                    wdata_d = wdata_arr[pick_idx];
                    state_d = ADDR;
                end
            end
            // The latched payload is presented regardless of req_i so the transfer cannot be retracted.
            ADDR: begin
                obi.req   = 1'b1;
                obi.addr  = addr_q;
                obi.we    = we_q;
                obi.be    = be_q;
                obi.wdata = wdata_q;
                if (obi.gnt) begin
                    gnt_o[sel_q] = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                obi.rready = 1'b1;
                if (obi.rvalid) begin
                    rvalid_o[sel_q] = 1'b1;
                    rdata_o         = obi.rdata;
                    err_o           = obi.err;
                    rr_ptr_d        = (sel_q == IDX_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// tb/tb_obi_rr_arbiter.sv - self-checking bench for obi_rr_arbiter
module tb_obi_rr_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic [N-1:0] req;
        int           wait_n;
        logic [31:0]  rdata;
        logic         err;
        int           exp_id;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
    } sb_t;

    logic              clk;
    logic              reset_ni;
    logic [N-1:0]      req_i;
    logic [N-1:0]      we_i;
    logic [N*AW-1:0]   addr_i;
    logic [N*DW/8-1:0] be_i;
    logic [N*DW-1:0]   wdata_i;
    logic [N-1:0]      gnt_o;
    logic [N-1:0]      rvalid_o;
    logic [DW-1:0]     rdata_o;
    logic              err_o;

    logic [AW-1:0]     addr_m  [N];
    logic              we_m    [N];
    logic [DW/8-1:0]   be_m    [N];
    logic [DW-1:0]     wdata_m [N];

    sb_t  sb[$];
    vec_t vecs[12];
    int   checks = 0;
    int   errors = 0;

    obi_rr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) obi ();

    obi_rr_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .req_i    (req_i),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .be_i     (be_i),
        .wdata_i  (wdata_i),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .obi      (obi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            addr_i[i*AW +: AW]       = addr_m[i];
            we_i[i]                  = we_m[i];
            be_i[i*DW/8 +: DW/8]     = be_m[i];
            wdata_i[i*DW +: DW]      = wdata_m[i];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_obi_req"}, obi.req, 0);
        chk({tag, "_rready"}, obi.rready, 0);
        chk({tag, "_gnt_o"}, gnt_o, 0);
        chk({tag, "_rvalid_o"}, rvalid_o, 0);
        chk({tag, "_rdata_o"}, rdata_o, 0);
        chk({tag, "_err_o"}, err_o, 0);
        chk({tag, "_addr"}, obi.addr, 0);
        chk({tag, "_wdata"}, obi.wdata, 0);
    endtask

    // Entered at a negedge with the DUT in IDLE; returns at the negedge after the response (IDLE again).
    task automatic run_txn(input logic [N-1:0] req, input int wait_n, input logic [31:0] rdata,
                           input logic err, input int exp_id, input bit drop);
        sb_t e;
        req_i = req;
        #1;
        chk("idle_obi_req", obi.req, 0);
        chk("idle_gnt_o", gnt_o, 0);
        e.id = exp_id; e.rdata = rdata; e.err = err;
        sb.push_back(e);
        @(negedge clk);
        if (drop) req_i = '0;
        for (int w = 0; w <= wait_n; w++) begin
            obi.gnt = (w == wait_n);
            #1;
            chk("addr_obi_req", obi.req, 1);
            chk("addr_obi_addr", obi.addr, addr_m[exp_id]);
            chk("addr_obi_we", obi.we, we_m[exp_id]);
            chk("addr_obi_be", obi.be, be_m[exp_id]);
            chk("addr_obi_wdata", obi.wdata, wdata_m[exp_id]);
            chk("addr_gnt_o", gnt_o, (w == wait_n) ? (64'(1) << exp_id) : 64'(0));
            @(negedge clk);
        end
        obi.gnt    = 1'b0;
        obi.rvalid = 1'b1;
        obi.rdata  = rdata;
        obi.err    = err;
        #1;
        chk("resp_rready", obi.rready, 1);
        chk("resp_obi_req", obi.req, 0);
        if (rvalid_o != '0 && sb.size() > 0) begin
            e = sb.pop_front();
            chk("resp_rvalid_o", rvalid_o, 64'(1) << e.id);
            chk("resp_rdata_o", rdata_o, e.rdata);
            chk("resp_err_o", err_o, e.err);
        end else begin
            chk("resp_rvalid_seen", rvalid_o, 64'(1) << exp_id);
            sb.delete();
        end
        @(negedge clk);
        obi.rvalid = 1'b0;
        obi.rdata  = '0;
        obi.err    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{4'b0010, 2, 32'h1A73_BEEF, 1'b0, 1};
        vecs[1]  = '{4'b0100, 0, 32'h0000_0001, 1'b0, 2};
        vecs[2]  = '{4'b0101, 1, 32'h5555_AAAA, 1'b0, 0};
        vecs[3]  = '{4'b0101, 0, 32'h1234_5678, 1'b0, 2};
        vecs[4]  = '{4'b1111, 0, 32'h3333_3333, 1'b0, 3};
        vecs[5]  = '{4'b1111, 0, 32'h0000_0A00, 1'b0, 0};
        vecs[6]  = '{4'b1111, 0, 32'h0000_0A01, 1'b0, 1};
        vecs[7]  = '{4'b1111, 0, 32'h0000_0A02, 1'b0, 2};
        vecs[8]  = '{4'b1111, 0, 32'h0000_0A03, 1'b0, 3};
        vecs[9]  = '{4'b1111, 0, 32'h0000_0A04, 1'b0, 0};
        vecs[10] = '{4'b0001, 0, 32'hBAD0_BAD0, 1'b1, 0};
        vecs[11] = '{4'b0011, 0, 32'h7777_0001, 1'b0, 1};

        for (int i = 0; i < N; i++) begin
            addr_m[i]  = 32'hA000_0000 + 32'(i * 16);
            we_m[i]    = 1'b0;
            be_m[i]    = 4'h1 << i;
            wdata_m[i] = 32'h1111_1111 * 32'(i + 1);
        end
        addr_m[1]  = 32'hDEAD_BEEF;
        req_i      = '0;
        obi.gnt    = 1'b0;
        obi.rvalid = 1'b0;
        obi.rdata  = '0;
        obi.err    = 1'b0;
        reset_ni   = 1'b1;

        #2 reset_ni = 1'b0;
        #1 chk_all_zero("rst0");
        @(negedge clk);
        reset_ni = 1'b1;

        foreach (vecs[i])
            run_txn(vecs[i].req, vecs[i].wait_n, vecs[i].rdata, vecs[i].err, vecs[i].exp_id, 1'b0);

        // Write with a long grant stall while the requester withdraws its request.
        addr_m[3]  = 32'h0000_0100;
        we_m[3]    = 1'b1;
        be_m[3]    = 4'hF;
        wdata_m[3] = 32'hCAFE_F00D;
        run_txn(4'b1000, 5, 32'h0, 1'b0, 3, 1'b1);

        // Leave rr_ptr at 2, then abandon a transfer in RESP via reset.
        run_txn(4'b0010, 0, 32'h2222_0000, 1'b0, 1, 1'b0);
        req_i = 4'b0100;
        @(negedge clk);
        req_i   = '0;
        obi.gnt = 1'b1;
        #1 chk("mid_gnt_o", gnt_o, 4'b0100);
        @(negedge clk);
        obi.gnt = 1'b0;
        #1 chk("mid_rready", obi.rready, 1);
        #2 reset_ni = 1'b0;
        #1 chk_all_zero("rst_resp");
        @(negedge clk);
        reset_ni   = 1'b1;
        obi.rvalid = 1'b1;
        obi.rdata  = 32'h1234_5678;
        obi.err    = 1'b1;
        obi.gnt    = 1'b1;
        #1;
        chk("stray_rvalid_o", rvalid_o, 0);
        chk("stray_rdata_o", rdata_o, 0);
        chk("stray_err_o", err_o, 0);
        chk("stray_gnt_o", gnt_o, 0);
        @(negedge clk);
        obi.rvalid = 1'b0;
        obi.rdata  = '0;
        obi.err    = 1'b0;
        obi.gnt    = 1'b0;
        #1 chk("stray_stays_idle", obi.req, 0);
        run_txn(4'b1111, 0, 32'h0F0F_0F0F, 1'b0, 0, 1'b0);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
